// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared FSM encodings and word-width helpers for the UART TX arbiter
package uart_tx_arbiter_pkg;

    localparam int STATE_SIZE = 2;

    typedef enum logic [STATE_SIZE-1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_BUSY   = 2'd3
    } arb_state_e;

    localparam int DATA_WIDTH_BYTES_DEFAULT = 6;
    localparam int W = DATA_WIDTH_BYTES_DEFAULT * 8;

    // Bit width of one timetag word for a given byte count
    function automatic int word_width(input int bytes);
        return bytes * 8;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// rtl/uart_tx_arbiter_rr_priority_picker.sv - round-robin first-set-bit search starting after the last served channel
module rr_priority_picker #(
    parameter int NUM_CH  = 4,
    parameter int CH_ID_W = 2
) (
    input  logic [NUM_CH-1:0]  req_i,
    input  logic [CH_ID_W-1:0] last_i,
    output logic               any_o,
    output logic [CH_ID_W-1:0] index_o
);

    // Walk last+1, last+2, ... wrapping, and take the first requesting channel
    always_comb begin
        int cand;
        cand    = 0;
        any_o   = 1'b0;
        index_o = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = (int'(last_i) + k) % NUM_CH;
            if (!any_o && req_i[cand]) begin
                any_o   = 1'b1;
                index_o = CH_ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one serial transmitter among buffered timetag requesters
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int DATA_WIDTH_BYTES = DATA_WIDTH_BYTES_DEFAULT,
    parameter int CH_ID_W          = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CH-1:0]                  req_valid,
    input  logic [NUM_CH*DATA_WIDTH_BYTES*8-1:0] req_data,
    output logic [NUM_CH-1:0]                  pending,
    output logic [NUM_CH-1:0]                  overflow,
    input  logic                               overflow_clr,
    output logic [DATA_WIDTH_BYTES*8-1:0]      tx_data,
    output logic                               tx_trigger,
    input  logic                               tx_over,
    output logic                               busy,
    output logic [CH_ID_W-1:0]                 grant_id
);

    localparam int WW = word_width(DATA_WIDTH_BYTES);

    arb_state_e          state_q, state_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [NUM_CH-1:0]   ovf_q, ovf_d;
    logic [WW-1:0]       word_q [NUM_CH];
    logic [WW-1:0]       word_d [NUM_CH];
    logic [CH_ID_W-1:0]  last_q, last_d;
    logic [CH_ID_W-1:0]  grant_q, grant_d;
    logic [WW-1:0]       tx_data_q, tx_data_d;
    logic                trig_q, trig_d;
    logic                busy_q, busy_d;

    logic                pick_any;
    logic [CH_ID_W-1:0]  pick_idx;
    logic [WW-1:0]       pick_word;
    logic                launch;

    rr_priority_picker #(
        .NUM_CH  (NUM_CH),
        .CH_ID_W (CH_ID_W)
    ) u_picker (
        .req_i   (pend_q),
        .last_i  (last_q),
        .any_o   (pick_any),
        .index_o (pick_idx)
    );

    // The launch edge is the end of ARB, so the trigger is visible in the LAUNCH cycle
    assign launch = (state_q == ST_ARB) && pick_any;

    // Select the buffered word of the channel being granted
    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_ID_W'(i) == pick_idx) begin
                pick_word = word_q[i];
            end
        end
    end

    // Per-channel capture, drop detection, launch release and sticky-overflow handling
    always_comb begin
        pend_d = pend_q;
        ovf_d  = overflow_clr ? '0 : ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            word_d[i] = word_q[i];
            if (launch && (CH_ID_W'(i) == pick_idx)) begin
                // A word arriving as the old one leaves simply refills the slot
                if (req_valid[i]) begin
                    word_d[i] = req_data[i*WW +: WW];
                    pend_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b0;
                end
            end else if (req_valid[i]) begin
                if (!pend_q[i]) begin
                    word_d[i] = req_data[i*WW +: WW];
                    pend_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; tx_over outside BUSY is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|pend_q) state_d = ST_ARB;
            ST_ARB:    state_d = pick_any ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: state_d = ST_BUSY;
            ST_BUSY:   if (tx_over) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered transmitter-side outputs
    always_comb begin
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        busy_d    = busy_q;
        last_d    = last_q;
        trig_d    = 1'b0;
        if (launch) begin
            grant_d   = pick_idx;
            tx_data_d = pick_word;
            trig_d    = 1'b1;
            busy_d    = 1'b1;
        end
        if ((state_q == ST_BUSY) && tx_over) begin
            busy_d = 1'b0;
            last_d = grant_q;
        end
    end

    // Registered outputs, buffers and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q    <= '0;
            ovf_q     <= '0;
            last_q    <= CH_ID_W'(NUM_CH - 1);
            grant_q   <= '0;
            tx_data_q <= '0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            for (int i = 0; i < NUM_CH; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

    assign pending    = pend_q;
    assign overflow   = ovf_q;
    assign tx_data    = tx_data_q;
    assign tx_trigger = trig_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_serialized transmitter among NUM_CH timetag requesters, e.g. per-channel event stampers.
- Each requester pulses a word in; the block holds it in a one-deep per-channel buffer.
- Channels are picked round-robin. The block drives the sender's data_in/trigger and waits for its transmission_over pulse before launching the next word.
- Sits between the timetag capture logic and the UART output path.

Parameters:
- NUM_CH, 4, number of requesters (2..8).
- DATA_WIDTH_BYTES, 6, word width in bytes; must match the attached uart_serialized.
- CH_ID_W, 2, width of grant_id; must satisfy 2**CH_ID_W >= NUM_CH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CH  per-channel 1-cycle word strobe.
- req_data  in  NUM_CH*DATA_WIDTH_BYTES*8  flattened words; channel i occupies slice [i*W +: W], W=DATA_WIDTH_BYTES*8.
- pending  out  NUM_CH  per-channel buffer-full flags.
- overflow  out  NUM_CH  sticky per-channel drop flags.
- overflow_clr  in  1  synchronous clear of all overflow bits.
- tx_data  out  DATA_WIDTH_BYTES*8  to uart_serialized data_in.
- tx_trigger  out  1  to uart_serialized trigger; 1-cycle pulse.
- tx_over  in  1  from uart_serialized transmission_over.
- busy  out  1  high from launch until tx_over.
- grant_id  out  CH_ID_W  channel currently or last granted.

Behaviour:
- Reset (asynchronous, reset=0): all outputs and internal registers clear.
  - pending=0, overflow=0, tx_data=0, tx_trigger=0, busy=0, grant_id=0.
  - last-served pointer = NUM_CH-1, so channel 0 has first priority.
- Capture, every cycle, per channel i:
  - If req_valid[i] and not pending[i]: buf[i]<=slice i, pending[i]<=1.
  - If req_valid[i] and pending[i] (and not the clear case below): the new word is dropped, buf[i] is unchanged, overflow[i]<=1.
- Clear on launch: in the LAUNCH cycle, if req_valid[sel] is also high, the new word is captured. pending[sel] stays 1, buf[sel]=new word, no overflow.
- overflow_clr: clears all overflow bits. A same-cycle drop on any channel wins for that channel.
- FSM states: IDLE, ARB, LAUNCH, BUSY. All outputs are registered.
  - IDLE: if |pending -> ARB.
  - ARB: sel <= first set pending bit searching from last+1, wrapping modulo NUM_CH. grant_id<=sel. -> LAUNCH.
  - LAUNCH: tx_data<=buf[sel], tx_trigger<=1 for one cycle, pending[sel]<=0 (subject to the clear-on-launch rule), busy<=1. -> BUSY.
  - BUSY: tx_trigger=0. tx_data is held stable until tx_over. On tx_over: busy<=0, last<=sel. -> IDLE.
- Latency: req_valid on an idle system (cycle 0) -> pending at 1, ARB at 2, tx_trigger high at 3.
- Back-to-back: next tx_trigger comes ≥3 cycles after tx_over (IDLE, ARB, LAUNCH).
- tx_over while not in BUSY is ignored.
- uart_serialized runs its own synchronous reset from the same domain. The integrator asserts both resets together.
- Reset mid-transfer: the FSM returns to IDLE immediately and the buffered words are lost. No trigger is issued until a new req_valid arrives.

Decomposition:
- Shared package/include: FSM state encodings (IDLE=0, ARB=1, LAUNCH=2, BUSY=3, STATE_SIZE=2) and the W=DATA_WIDTH_BYTES*8 localparam.
- One sub-module: rr_priority_picker (NUM_CH, CH_ID_W). Combinational.
  - Inputs: request vector, last pointer.
  - Outputs: any, index.
- Top level instantiates uart_arbiter core logic only. The uart_serialized instance is made by the integrator.

Test Plan:
- Single word: req_valid[2]=1 with data 0x0000_00AB_CDEF at cycle 0 → tx_trigger at cycle 3 with tx_data=0x0000_00ABCDEF, grant_id=2, pending[2]=0 from cycle 3, busy=1 until a tx_over pulse 50 cycles later.
- Round-robin: all four channels load 0x11..,0x22..,0x33..,0x44.. in one cycle → grants in order 0,1,2,3, one per tx_over. Then reload ch3 and ch0 while serving ch1 → next order 2,3,0.
- Overflow: ch1 receives two strobes 5 cycles apart while busy on ch0 → first word is kept, overflow[1]=1. overflow_clr then gives overflow=0. A drop coincident with overflow_clr leaves overflow[1]=1.
- Clear-on-launch: req_valid[0] with 0x55 exactly in ch0's LAUNCH cycle → tx_data is the old word, pending[0] stays 1, ch0 is re-granted after tx_over if no others are pending, overflow[0]=0.
- Spurious tx_over in IDLE → no state change, no trigger.
- Reset mid-BUSY (reset=0 for 2 cycles, asynchronous edge) → all outputs 0 at once, no tx_trigger afterwards until a new req_valid.
